// File: rtl/aes_pkg.sv
// Shared AES-128 tables, GF(2^8) helpers, key-expansion step and FSM encoding
// for the iterative inverse cipher.
package aes_pkg;

   localparam int unsigned NR      = 10;
   localparam int unsigned BLOCK_W = 128;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEYEXP,
      ST_ADDK,
      ST_ROUND,
      ST_FIN
   } fsm_t;

   // Byte table stored first-entry-at-MSB, so entry x lives at index ~x.
   typedef logic [255:0][7:0] sbox_tbl_t;

   localparam sbox_tbl_t SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic sbox_tbl_t gen_inv_sbox();
      sbox_tbl_t t;
      t = '0;
      for (int i = 0; i < 256; i++) begin
         t[~SBOX[~8'(i)]] = 8'(i);
      end
      return t;
   endfunction

   localparam sbox_tbl_t INV_SBOX = gen_inv_sbox();

   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      return SBOX[~b];
   endfunction

   function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
      return INV_SBOX[~b];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // One AES-128 key-schedule step: previous round key -> next round key.
   function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      logic [31:0] w3;
      t  = {k[23:0], k[31:24]};
      t  = {sub_byte(t[31:24]), sub_byte(t[23:16]), sub_byte(t[15:8]), sub_byte(t[7:0])}
           ^ {rc, 24'h000000};
      w0 = k[127:96] ^ t;
      w1 = k[95:64]  ^ w0;
      w2 = k[63:32]  ^ w1;
      w3 = k[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns when i_mix_en is set.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [BLOCK_W-1:0] i_state,
   input  logic [BLOCK_W-1:0] i_rkey,
   input  logic               i_mix_en,
   output logic [BLOCK_W-1:0] o_state_c
);

   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic mix);
      logic [7:0]   b [16];
      logic [7:0]   a0;
      logic [7:0]   a1;
      logic [7:0]   a2;
      logic [7:0]   a3;
      logic [127:0] res;
      int           src;
      // Byte (row r, column c) sits at index 4c+r; row r rotates right by r.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src        = 4 * ((c - r + 4) % 4) + r;
            b[4*c + r] = inv_sub_byte(s[127 - 8*src -: 8]) ^ k[127 - 8*(4*c + r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         a0 = b[4*c];
         a1 = b[4*c + 1];
         a2 = b[4*c + 2];
         a3 = b[4*c + 3];
         if (mix) begin
            b[4*c]     = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            b[4*c + 1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            b[4*c + 2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            b[4*c + 3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
         end
      end
      res = '0;
      for (int i = 0; i < 16; i++) begin
         res[127 - 8*i -: 8] = b[i];
      end
      return res;
   endfunction

   assign o_state_c = inv_round(i_state, i_rkey, i_mix_en);

endmodule

// File: rtl/aes128_decrypt_core.sv
// Iterative AES-128 inverse cipher, one round per clock, START/DONE handshake.
// Define AES_DEC_KEYCACHE_EN to skip key expansion when the key repeats.
module aes128_decrypt_core
   import aes_pkg::*;
#(
   parameter int unsigned NR       = aes_pkg::NR,
   parameter bit          HOLD_OUT = 1'b1
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               START,
   input  logic [BLOCK_W-1:0] CIPHER_TXT,
   input  logic [BLOCK_W-1:0] AESKEY,
   output logic [BLOCK_W-1:0] PLAIN_TXT,
   output logic               BUSY,
   output logic               DONE
);

   if (NR != 10) begin : g_bad_nr
      $error("aes128_decrypt_core supports only NR=10 (AES-128)");
   end

   localparam logic [3:0] LAST_RK = 4'(NR);

   fsm_t               r_fsm;
   logic [BLOCK_W-1:0] r_state;
   logic [BLOCK_W-1:0] r_rk [0:NR];
   logic [3:0]         r_rnd;
   logic [BLOCK_W-1:0] w_rkey;
   logic [BLOCK_W-1:0] w_round;
   logic               w_mix_en;

`ifdef AES_DEC_KEYCACHE_EN
   logic r_key_vld;
   logic w_key_hit;
   assign w_key_hit = r_key_vld && (AESKEY == r_rk[0]);
`endif

   // r_rnd doubles as the round-key index: 10 in ADDK, 9..1 in ROUND, 0 in FIN.
   assign w_rkey   = r_rk[r_rnd];
   assign w_mix_en = (r_fsm == ST_ROUND);

   aes_inv_round u_inv_round (
      .i_state   (r_state),
      .i_rkey    (w_rkey),
      .i_mix_en  (w_mix_en),
      .o_state_c (w_round)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_fsm     <= ST_IDLE;
         r_state   <= '0;
         r_rnd     <= '0;
         PLAIN_TXT <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         for (int k = 0; k <= NR; k++) begin
            r_rk[k] <= '0;
         end
`ifdef AES_DEC_KEYCACHE_EN
         r_key_vld <= 1'b0;
`endif
      end else begin
         DONE <= 1'b0;
         case (r_fsm)
            ST_IDLE: begin
               if (START) begin
                  r_state <= CIPHER_TXT;
                  BUSY    <= 1'b1;
                  if (!HOLD_OUT) PLAIN_TXT <= '0;
`ifdef AES_DEC_KEYCACHE_EN
                  if (w_key_hit) begin
                     r_rnd <= LAST_RK;
                     r_fsm <= ST_ADDK;
                  end else begin
                     r_rk[0]   <= AESKEY;
                     r_key_vld <= 1'b0;
                     r_rnd     <= 4'd1;
                     r_fsm     <= ST_KEYEXP;
                  end
`else
                  r_rk[0] <= AESKEY;
                  r_rnd   <= 4'd1;
                  r_fsm   <= ST_KEYEXP;
`endif
               end
            end
            ST_KEYEXP: begin
               r_rk[r_rnd] <= key_step(r_rk[r_rnd - 4'd1], rcon(r_rnd));
               if (r_rnd == LAST_RK) begin
                  r_fsm <= ST_ADDK;
`ifdef AES_DEC_KEYCACHE_EN
                  r_key_vld <= 1'b1;
`endif
               end else begin
                  r_rnd <= r_rnd + 4'd1;
               end
            end
            ST_ADDK: begin
               r_state <= r_state ^ w_rkey;
               r_rnd   <= LAST_RK - 4'd1;
               r_fsm   <= ST_ROUND;
            end
            ST_ROUND: begin
               r_state <= w_round;
               r_rnd   <= r_rnd - 4'd1;
               if (r_rnd == 4'd1) r_fsm <= ST_FIN;
            end
            ST_FIN: begin
               PLAIN_TXT <= w_round;
               DONE      <= 1'b1;
               BUSY      <= 1'b0;
               r_fsm     <= ST_IDLE;
            end
            default: r_fsm <= ST_IDLE;
         endcase
      end
   end

endmodule
